// File: rtl/mod_sq_scheduler.sv
// Time-shares one registered multiplier to compute |s|^2 = I*I + Q*Q per accepted sample.
// Five cycles per sample: the result is held in OUT until downstream accepts it.
module mod_sq_scheduler #(
  parameter int WIDTH  = 8,
  parameter int PWIDTH = 16,
  parameter int CWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_i,
  input  logic [WIDTH-1:0]  in_q,
  input  logic [7:0]        in_mask,
  output logic [WIDTH-1:0]  mul_a,
  output logic [WIDTH-1:0]  mul_b,
  output logic [7:0]        mul_mask,
  output logic              mul_en,
  input  logic [PWIDTH-1:0] mul_r,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PWIDTH-1:0] out_mag,
  output logic [CWIDTH-1:0] sample_cnt
);

  typedef enum logic [2:0] {IDLE, ISSUE_I, ISSUE_Q, SUM, OUT} state_t;

  state_t              state_q;
  logic [WIDTH-1:0]    i_q;
  logic [WIDTH-1:0]    q_q;
  logic [7:0]          mask_q;
  logic [PWIDTH-1:0]   acc_q;
  logic [PWIDTH-1:0]   mag_q;
  logic [CWIDTH-1:0]   cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      q_q     <= '0;
      mask_q  <= '0;
      acc_q   <= '0;
      mag_q   <= '0;
      cnt_q   <= '0;
    end else if (flush) begin
      // Abort wins over any accept or delivery this cycle.
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            i_q     <= in_i;
            q_q     <= in_q;
            mask_q  <= in_mask;
            state_q <= ISSUE_I;
          end
        end
        ISSUE_I: state_q <= ISSUE_Q;
        ISSUE_Q: begin
          acc_q   <= mul_r;
          state_q <= SUM;
        end
        SUM: begin
          mag_q   <= acc_q + mul_r;
          state_q <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            cnt_q   <= cnt_q + 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == OUT);
  assign mul_en     = (state_q == ISSUE_I) || (state_q == ISSUE_Q);
  assign mul_a      = (state_q == ISSUE_I) ? i_q : (state_q == ISSUE_Q) ? q_q : '0;
  assign mul_b      = mul_a;
  assign mul_mask   = mask_q;
  assign out_mag    = mag_q;
  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_mod_sq_scheduler.sv
// Directed bench for mod_sq_scheduler with a registered signed-product multiplier model.
module tb_mod_sq_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_i = '0;
  logic [7:0]  in_q = '0;
  logic [7:0]  in_mask = '0;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic [7:0]  mul_mask;
  logic        mul_en;
  logic [15:0] mul_r;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_mag;
  logic [3:0]  sample_cnt;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [3:0]  exp_cnt = '0;

  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mul_r <= '0;
    else     mul_r <= 16'($signed(mul_a) * $signed(mul_b));
  end

  mod_sq_scheduler #(.WIDTH(8), .PWIDTH(16), .CWIDTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_i(in_i), .in_q(in_q), .in_mask(in_mask),
    .mul_a(mul_a), .mul_b(mul_b), .mul_mask(mul_mask), .mul_en(mul_en),
    .mul_r(mul_r),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mag(out_mag), .sample_cnt(sample_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in IDLE with out_ready high; ends in IDLE after the delivery.
  task automatic run_sample(input logic [7:0] i, input logic [7:0] q,
                            input logic [7:0] m, input logic [15:0] exp_mag);
    in_i = i; in_q = q; in_mask = m; in_valid = 1'b1;
    chk("run_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("run_out_valid", 32'(out_valid), 32'd1);
    chk("run_out_mag", 32'(out_mag), 32'(exp_mag));
    tick();
    exp_cnt = exp_cnt + 4'd1;
    chk("run_cnt", 32'(sample_cnt), 32'(exp_cnt));
  endtask

  initial begin
    #12 rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_mag", 32'(out_mag), 32'd0);
    chk("rst_cnt", 32'(sample_cnt), 32'd0);
    chk("rst_mul_a", 32'(mul_a), 32'd0);
    chk("rst_mul_en", 32'(mul_en), 32'd0);
    chk("rst_mul_mask", 32'(mul_mask), 32'd0);

    // Basic, cycle by cycle
    tick();
    in_i = 8'h10; in_q = 8'h20; in_mask = 8'hA5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("c1_mul_a", 32'(mul_a), 32'h10);
    chk("c1_mul_b", 32'(mul_b), 32'h10);
    chk("c1_mul_en", 32'(mul_en), 32'd1);
    chk("c1_mul_mask", 32'(mul_mask), 32'hA5);
    chk("c1_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("c2_mul_a", 32'(mul_a), 32'h20);
    chk("c2_mul_en", 32'(mul_en), 32'd1);
    tick();
    chk("c3_mul_en", 32'(mul_en), 32'd0);
    chk("c3_mul_a", 32'(mul_a), 32'd0);
    chk("c3_out_valid", 32'(out_valid), 32'd0);
    tick();
    chk("c4_out_valid", 32'(out_valid), 32'd1);
    chk("c4_out_mag", 32'(out_mag), 32'h0500);
    tick();
    exp_cnt = 4'd1;
    chk("c5_out_valid", 32'(out_valid), 32'd0);
    chk("c5_in_ready", 32'(in_ready), 32'd1);
    chk("c5_cnt", 32'(sample_cnt), 32'd1);
    chk("c5_mask_hold", 32'(mul_mask), 32'hA5);

    // Extremes
    run_sample(8'h80, 8'h80, 8'h01, 16'h8000);
    run_sample(8'h7F, 8'h81, 8'h02, 16'h7E02);
    run_sample(8'h00, 8'h00, 8'h03, 16'h0000);

    // Backpressure: out_ready low for three OUT cycles
    out_ready = 1'b0;
    in_i = 8'h03; in_q = 8'hFC; in_mask = 8'h04; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    for (int k = 0; k < 3; k++) begin
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_mag", 32'(out_mag), 32'h0019);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    chk("bp_release_valid", 32'(out_valid), 32'd1);
    tick();
    exp_cnt = exp_cnt + 4'd1;
    chk("bp_idle", 32'(in_ready), 32'd1);
    chk("bp_cnt", 32'(sample_cnt), 32'(exp_cnt));

    // Back-to-back with in_valid held high
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [7:0]  bi, bq;
      logic [15:0] bm;
      case (k)
        0: begin bi = 8'h01; bq = 8'h02; bm = 16'h0005; end
        1: begin bi = 8'h7F; bq = 8'h00; bm = 16'h3F01; end
        2: begin bi = 8'hFF; bq = 8'hFF; bm = 16'h0002; end
        default: begin bi = 8'h05; bq = 8'h05; bm = 16'h0032; end
      endcase
      in_i = bi; in_q = bq;
      chk("b2b_accept", 32'(in_ready), 32'd1);
      tick();
      chk("b2b_busy", 32'(in_ready), 32'd0);
      tick(); tick(); tick();
      chk("b2b_out_mag", 32'(out_mag), 32'(bm));
      tick();
      if (k == 3) in_valid = 1'b0;
    end
    exp_cnt = exp_cnt + 4'd4;
    chk("b2b_cnt", 32'(sample_cnt), 32'(exp_cnt));

    // Flush in ISSUE_Q
    in_i = 8'h09; in_q = 8'h09; in_mask = 8'h11; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_idle", 32'(in_ready), 32'd1);
    chk("fl_mul_en", 32'(mul_en), 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("fl_no_valid", 32'(out_valid), 32'd0);
      tick();
    end
    chk("fl_cnt", 32'(sample_cnt), 32'(exp_cnt));

    // Flush beats an accept in IDLE
    in_i = 8'h22; in_mask = 8'h3C; in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    chk("fl_acc_idle", 32'(in_ready), 32'd1);
    chk("fl_acc_mask", 32'(mul_mask), 32'h11);
    chk("fl_acc_mul_en", 32'(mul_en), 32'd0);

    // Flush in OUT with out_ready high discards the transfer
    in_i = 8'h02; in_q = 8'h02; in_mask = 8'h22; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("flo_valid", 32'(out_valid), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flo_no_valid", 32'(out_valid), 32'd0);
    chk("flo_cnt", 32'(sample_cnt), 32'(exp_cnt));

    // Async reset during SUM
    in_i = 8'h10; in_q = 8'h10; in_mask = 8'h5A; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("ar_pre_mag", 32'(out_mag), 32'h0008);
    #1 rst = 1'b1;
    #1;
    chk("ar_in_ready", 32'(in_ready), 32'd1);
    chk("ar_out_valid", 32'(out_valid), 32'd0);
    chk("ar_out_mag", 32'(out_mag), 32'd0);
    chk("ar_cnt", 32'(sample_cnt), 32'd0);
    chk("ar_mul_mask", 32'(mul_mask), 32'd0);
    chk("ar_mul_a", 32'(mul_a), 32'd0);
    chk("ar_mul_en", 32'(mul_en), 32'd0);
    #1 rst = 1'b0;
    exp_cnt = '0;
    tick();
    run_sample(8'h04, 8'hFD, 8'h77, 16'h0019);

    // Counter wrap on the 16th delivery
    for (int k = 0; k < 14; k++) run_sample(8'(k), 8'h01, 8'h00, 16'(k * k + 1));
    chk("wrap_pre", 32'(sample_cnt), 32'd15);
    run_sample(8'h02, 8'h03, 8'h00, 16'h000D);
    chk("wrap_zero", 32'(sample_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
